// File: rtl/imm_gen_stage_pkg.sv
// Shared types and constants for the immediate-generation stage.
//   XLEN_DEFAULT / INST_WIDTH : default datapath width and raw instruction width
//   OP_*                      : major opcodes recognised by the decoder
//   imm_type_e                : immediate format reported alongside imm_o
//   skid_state_e              : occupancy state of the output buffer
package imm_gen_stage_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned INST_WIDTH   = 32;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // IMM_NONE must stay the zero encoding: reset clears registers to '0.
  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_Z    = 3'd6
  } imm_type_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/imm_gen_stage_decode.sv
// Combinational immediate decoder.
//   inst_i     : raw 32-bit instruction
//   imm_o      : immediate, sign-extended (zero-extended for IMM_Z) to XLEN
//   imm_type_o : detected immediate format
//   illegal_o  : unknown opcode or non-32-bit encoding (inst_i[1:0] != 2'b11)
module imm_decode
  import imm_gen_stage_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic [INST_WIDTH-1:0] inst_i,
  output logic [XLEN-1:0]       imm_o,
  output imm_type_e             imm_type_o,
  output logic                  illegal_o
);

  logic [6:0]  opcode;
  logic [31:0] imm32;

  assign opcode = inst_i[6:0];

  // Build every format as a 32-bit signed value, then widen once.
  always_comb begin
    imm32      = '0;
    imm_type_o = IMM_NONE;
    illegal_o  = 1'b0;
    if (inst_i[1:0] != 2'b11) begin
      illegal_o = 1'b1;
    end else begin
      case (opcode)
        OP_ALUI, OP_LOAD, OP_JALR: begin
          imm_type_o = IMM_I;
          imm32      = {{20{inst_i[31]}}, inst_i[31:20]};
        end
        OP_STORE: begin
          imm_type_o = IMM_S;
          imm32      = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
        end
        OP_BRANCH: begin
          imm_type_o = IMM_B;
          imm32      = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                        inst_i[30:25], inst_i[11:8], 1'b0};
        end
        OP_JAL: begin
          imm_type_o = IMM_J;
          imm32      = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                        inst_i[20], inst_i[30:21], 1'b0};
        end
        OP_LUI, OP_AUIPC: begin
          imm_type_o = IMM_U;
          imm32      = {inst_i[31:12], 12'b0};
        end
        OP_SYSTEM: begin
          // Only the CSR-immediate forms (funct3[2]=1) carry a uimm in rs1.
          if (inst_i[14]) begin
            imm_type_o = IMM_Z;
            imm32      = {27'b0, inst_i[19:15]};
          end
        end
        OP_ALU: begin
          imm_type_o = IMM_NONE;
        end
        default: begin
          illegal_o = 1'b1;
        end
      endcase
    end
    // Sign-extending cast; IMM_Z has bit 31 clear so it stays zero-extended.
    imm_o = XLEN'($signed(imm32));
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage with optional 2-entry skid buffer.
//   clk_i, rst_ni         : clock, synchronous active-low reset
//   flush_i               : drop all buffered entries (data registers hold)
//   valid_i/ready_o       : upstream handshake carrying inst_i, pc_i
//   valid_o/ready_i       : downstream handshake carrying decoded fields
//   imm_o, imm_type_o     : extended immediate and its format
//   illegal_o             : malformed/unknown opcode flag
//   inst_o, pc_o          : instruction and PC passed through
module imm_gen_stage
  import imm_gen_stage_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_DEFAULT,
  parameter bit          SKID_EN = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [INST_WIDTH-1:0] inst_i,
  input  logic [XLEN-1:0]       pc_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [XLEN-1:0]       imm_o,
  output imm_type_e             imm_type_o,
  output logic                  illegal_o,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic [XLEN-1:0]       pc_o
);

  typedef struct packed {
    logic [XLEN-1:0]       imm;
    imm_type_e             imm_type;
    logic                  illegal;
    logic [INST_WIDTH-1:0] inst;
    logic [XLEN-1:0]       pc;
  } entry_t;

  skid_state_e state_q, state_d;
  entry_t      main_q, main_d;
  entry_t      skid_q, skid_d;
  entry_t      in_entry;
  logic        in_fire;
  logic        out_fire;

  logic [XLEN-1:0] dec_imm;
  imm_type_e       dec_type;
  logic            dec_illegal;

  // Decode on the input side so the registers hold final values.
  imm_decode #(
    .XLEN(XLEN)
  ) u_decode (
    .inst_i    (inst_i),
    .imm_o     (dec_imm),
    .imm_type_o(dec_type),
    .illegal_o (dec_illegal)
  );

  assign in_entry = '{imm: dec_imm, imm_type: dec_type, illegal: dec_illegal,
                      inst: inst_i, pc: pc_i};

  // Handshake flags decode registered state only; ready_i never reaches ready_o.
  assign ready_o  = SKID_EN ? (state_q != FULL) : (state_q == EMPTY);
  assign valid_o  = (state_q != EMPTY);
  assign in_fire  = valid_i && ready_o;
  assign out_fire = valid_o && ready_i;

  // Next-state and buffer-load logic; flush wins over any transfer.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = in_entry;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_entry;
          end else if (in_fire) begin
            // Main is stalled; the newer entry parks behind it.
            skid_d  = in_entry;
            state_d = FULL;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // State and data registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign imm_o      = main_q.imm;
  assign imm_type_o = main_q.imm_type;
  assign illegal_o  = main_q.illegal;
  assign inst_o     = main_q.inst;
  assign pc_o       = main_q.pc;

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
Registered, parametrised immediate-generation stage between fetch and decode/execute.
- Accepts one 32-bit instruction and its PC per valid/ready handshake.
- Classifies the immediate format and sign-extends to XLEN (32 or 64).
- Flags malformed or unknown opcodes.
- Presents the result one cycle later through an optional 2-entry skid buffer, so it supports both back-pressure and pipeline flush.

Parameters:
XLEN, 32, datapath width of imm_o/pc; legal values 32 or 64
SKID_EN, 1, 1 = 2-entry skid buffer (full throughput); 0 = single register (one accept every other cycle)

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_ni  in  1  reset, synchronous, active-low
flush_i  in  1  discard all buffered entries
valid_i  in  1  upstream instruction valid
ready_o  out  1  stage can accept this cycle
inst_i  in  INST_WIDTH  raw instruction
pc_i  in  XLEN  instruction PC
valid_o  out  1  output entry valid
ready_i  in  1  downstream accepts this cycle
imm_o  out  XLEN  extended immediate
imm_type_o  out  imm_type_e  format of imm_o
illegal_o  out  1  opcode unknown or inst_i[1:0] != 2'b11
inst_o  out  INST_WIDTH  instruction, passed through
pc_o  out  XLEN  PC, passed through

Behaviour:
- Transfers: input when valid_i && ready_o; output when valid_o && ready_i.
- Latency: 1 cycle from input transfer to valid_o, with no bubble when the buffer is empty.
- Ordering: entries leave strictly in arrival order.
- Format decode and sign-extension (s = inst[31], replicated up to XLEN):
  - ALUI/LOAD/JALR → IMM_I {s.., inst[31:20]}
  - STORE → IMM_S {s.., inst[31:25], inst[11:7]}
  - BRANCH → IMM_B {s.., inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - JAL → IMM_J {s.., inst[31], inst[19:12], inst[20], inst[30:21], 0}
  - LUI/AUIPC → IMM_U {s.., inst[31:12], 12'b0}; for XLEN=64, bits 63:32 = inst[31]
  - SYSTEM with funct3[2]=1 → IMM_Z, zero-extended inst[19:15]
  - OP_ALU, and SYSTEM with funct3[2]=0 → IMM_NONE, imm 0
- Illegal: any other opcode, or inst[1:0] != 2'b11 → imm_o=0, imm_type_o=IMM_NONE, illegal_o=1.
  - The entry is still delivered normally; the stage never drops it.
- State machine, SKID_EN=1: states EMPTY, ONE (main register valid), FULL (main + skid valid).
  - ready_o = (state != FULL), decoded from registered state only. There is no combinational path from ready_i to ready_o.
  - EMPTY: input transfer → ONE.
  - ONE: input transfer without output transfer → FULL (new entry into skid). Both transfer → ONE (main reloads). Output only → EMPTY.
  - FULL: output transfer → ONE (skid moves to main). No input transfer is possible in FULL.
- State machine, SKID_EN=0: states EMPTY and ONE only.
  - ready_o = (state == EMPTY).
  - ONE → EMPTY on output transfer.
- valid_o = (state != EMPTY). Output fields hold stable while valid_o && !ready_i.
- flush_i: next state = EMPTY.
  - A simultaneous input transfer is discarded; flush has priority.
  - valid_o=0 and ready_o=1 in the following cycle.
  - Data registers hold their values.
- Reset (rst_ni=0 at an edge): state EMPTY, so valid_o=0 and ready_o=1 after the edge.
  - imm_o, inst_o, pc_o = 0; imm_type_o = IMM_NONE; illegal_o = 0.
  - Reset mid-transfer drops all entries.
  - Reset has priority over flush_i.
- Decode happens before the register; the registered fields are the decoded values.

Decomposition:
- pkg_config additions:
  - XLEN_DEFAULT
  - imm_type_e enum {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_Z}
  - OP_ALU, OP_SYSTEM opcode constants, if absent
  - skid_state_e {EMPTY, ONE, FULL}
- Sub-module imm_decode: purely combinational, parametrised by XLEN. Takes inst_i and produces imm, type and illegal. It is instantiated once on the input side; imm_gen_stage holds only the registers and the FSM.

Test Plan:
- XLEN=32, input 0xFFF00093 (addi −1) with ready_i=1 → next cycle valid_o=1, imm_o=0xFFFFFFFF, IMM_I, illegal_o=0.
- XLEN=64, 0x800000B7 (lui) → imm_o=0xFFFFFFFF_80000000, IMM_U. Then 0x800000EF (jal) → 0xFFFFFFFF_FFF00000, IMM_J.
- XLEN=32:
  - 0xFE000FE3 (branch, all imm bits set) → 0xFFFFFFFE, IMM_B.
  - 0x3407D073 (csrrwi) → 0x0000000F, IMM_Z.
  - 0x00000000 → illegal_o=1, imm_o=0.
- Back-pressure: stream A,B,C back-to-back with ready_i=0.
  - A and B are accepted; ready_o=0 from the 2nd cycle after A; C is held upstream.
  - Raise ready_i: outputs A,B,C in order with no duplicates.
  - With SKID_EN=0, ready_o toggles and only one entry is ever held.
- Flush_i in state FULL, together with valid_i → next cycle valid_o=0, ready_o=1, and the concurrent input is never output.
- Drive rst_ni=0 for one edge while FULL → valid_o=0, ready_o=1, imm_o=0, IMM_NONE. A new input is accepted in the first cycle after reset.
